fpnew_divsqrt_multi_ctrl: RTL and testbench
===========================================

// Module: fpnew_divsqrt_multi_ctrl
// PURPOSE
// - Handshake/sequencing controller sitting directly upstream of the multi-cycle divsqrt unit.
// - Converts the lane valid/ready handshake into the unit's start/ready protocol and drives its reg_enable vector.
// - Carries tag/aux sideband alongside the operation and holds completion until the downstream accepts it.
// - One operation in flight in the iterative core; the pipeline stages around it may each hold one more.
// PARAMETERS
// - NumPipeRegs  0  total pipeline registers around the unit; sets the reg_enable_o width.
// - PipeConfig  AFTER  fpnew_pkg::pipe_config_t.
//   - NUM_INP_REGS = BEFORE ? N : DISTRIBUTED ? N/2 : 0.
//   - NUM_OUT_REGS = AFTER/INSIDE ? N : DISTRIBUTED ? (N+1)/2 : 0.
// - TagWidth  1  width of the tag sideband.
// - AuxWidth  1  width of the aux sideband.
// PORTS
// - clk_i  in  1  clock.
// - rst_i  in  1  synchronous reset, active-high.
// - in_valid_i  in  1  operation offered by the lane.
// - in_ready_o  out  1  operation accepted this cycle when in_valid_i is also high.
// - in_tag_i  in  TagWidth  tag sideband for the offered operation.
// - in_aux_i  in  AuxWidth  aux sideband for the offered operation.
// - flush_i  in  1  kill everything in flight; also forwarded to the unit by the lane.
// - unit_ready_i  in  1  unit can accept a start (unit fsm_ready_o).
// - unit_done_i  in  1  one-cycle pulse: unit result/status valid this cycle.
// - fsm_start_o  out  1  start pulse to the unit.
// - reg_enable_o  out  max(NumPipeRegs,1)  per-stage load enables, input stages first.
// - out_valid_o  out  1  completed result available.
// - out_ready_i  in  1  downstream accepts the result.
// - out_tag_o  out  TagWidth  tag of the completed operation.
// - out_aux_o  out  AuxWidth  aux of the completed operation.
// - busy_o  out  1  any stage or the unit holds a valid operation.
// BEHAVIOUR
// - Reset: all stage valids=0, state=IDLE, tag/aux regs=0.
//   - After reset: fsm_start_o=0, out_valid_o=0, reg_enable_o=0, busy_o=0.
//   - in_ready_o is combinational and may be 1 after reset.
// - Input pipe: NUM_INP_REGS valid/tag/aux stages.
//   - Stage i loads when (stage empty | next stage accepts); reg_enable_o[i]=load & upstream valid.
//   - Full throughput, no bubbles.
// - Core FSM states: IDLE, BUSY, HOLD.
//   - fsm_start_o = inp_last_valid & state==IDLE & unit_ready_i & ~flush_i.
//   - On start: latch tag/aux into core regs and go IDLE->BUSY; the last input stage is consumed that cycle.
//   - BUSY & unit_done_i & out-stage-0 accepts -> IDLE; completion enters the out pipe that cycle.
//   - BUSY & unit_done_i & out-stage-0 blocked -> HOLD.
//   - HOLD -> IDLE when out-stage-0 accepts.
//   - A new start is legal only from IDLE, so start and done never coincide.
// - Output pipe: NUM_OUT_REGS valid/tag/aux stages with backpressure.
//   - reg_enable_o[NUM_INP_REGS+i] = stage i loads a valid entry.
//   - With NUM_OUT_REGS=0: out_valid_o = (BUSY&unit_done_i)|HOLD.
// - Latency (empty pipe, out_ready_i=1):
//   - in accept -> fsm_start_o is NUM_INP_REGS cycles.
//   - unit_done_i -> out_valid_o is NUM_OUT_REGS cycles.
// - Backpressure:
//   - out_ready_i=0 stalls the output stages, then HOLD, then start, then the input stages.
//   - in_ready_o = stage-0 can load.
//   - Payload is held stable while out_valid_o & ~out_ready_i.
// - Flush takes priority over every event in the same cycle:
//   - Next cycle: all valids=0, state=IDLE, no fsm_start_o, no reg_enable_o.
//   - in_valid_i during flush is dropped: in_ready_o=0 while flush_i=1.
// - unit_done_i outside BUSY is ignored; assertion flags it.
// - reset mid-operation behaves exactly like flush and additionally clears tag/aux.
// STRUCTURE
// - fpnew_pkg gains num_inp_regs(PipeConfig,N) and num_out_regs(PipeConfig,N) functions.
//   - The divsqrt wrappers reuse these functions.
// - fsm_state_e {IDLE,BUSY,HOLD} stays local.
// - One sub-module: fpnew_hs_stage, a valid/ready register with a payload parameter.
//   - Instantiated per input/output stage.
//   - Exports its load strobe for reg_enable_o.
// TESTING
// - N=0: tag=5 accepted, unit_done_i 12 cycles later -> same cycle: out_valid_o=1, out_tag_o=5; fsm_start_o exactly once.
// - N=2 DISTRIBUTED: accept at cycle 0 -> fsm_start_o at cycle 1, reg_enable_o=2'b01 at cycle 0.
//   - done at cycle 20 -> out_valid_o at cycle 21, reg_enable_o=2'b10 at cycle 20.
// - N=0, out_ready_i=0 at done -> HOLD; out_valid_o stays 1 with tag stable 10 cycles; in_ready_o=0 once the pipe is full.
//   - Release -> accepted in 1 cycle, next start the following cycle.
// - Back-to-back: 3 ops tags 1,2,3 with unit_ready_i low 8 cycles after each start -> outputs in order 1,2,3, no duplicates.
// - flush_i asserted in the cycle of unit_done_i (state BUSY) -> no out_valid_o.
//   - Next cycle: busy_o=0, state IDLE, following op starts normally.
// - rst_i=1 for 1 cycle mid-HOLD with out_valid_o=1 -> next cycle: out_valid_o=0, fsm_start_o=0, reg_enable_o=0, out_tag_o=0.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FP unit definitions: pipeline placement options and the helpers that
// split a pipeline-register budget into input and output stages.
// Ports: none (package).
package fpnew_pkg;

  typedef enum logic [1:0] {
    BEFORE,
    AFTER,
    INSIDE,
    DISTRIBUTED
  } pipe_config_t;

  // Registers placed ahead of the unit for a given placement and budget.
  function automatic int num_inp_regs(pipe_config_t cfg, int n);
    case (cfg)
      BEFORE:      return n;
      DISTRIBUTED: return n / 2;
      default:     return 0;
    endcase
  endfunction

  // Registers placed behind the unit; DISTRIBUTED gives the odd one to the output.
  function automatic int num_out_regs(pipe_config_t cfg, int n);
    case (cfg)
      AFTER, INSIDE: return n;
      DISTRIBUTED:   return (n + 1) / 2;
      default:       return 0;
    endcase
  endfunction

endpackage

// File: rtl/fpnew_hs_stage.sv
// Purpose: one valid/ready register stage carrying a Width-bit payload.
// Latency: 1 cycle from in_valid_i accept to out_valid_o.
// Backpressure: accepts when empty or when downstream takes the current entry; never while flush_i.
// Ports: clk_i/rst_i/flush_i control; in_* upstream handshake + payload; out_* downstream
//        handshake + payload; load_o pulses when a valid entry is written.
module fpnew_hs_stage #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o,
  output logic             load_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  assign in_ready_o  = (~valid_q | out_ready_i) & ~flush_i;
  assign load_o      = in_valid_i & in_ready_o;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush_i)          valid_q <= 1'b0;
      else if (load_o)      valid_q <= 1'b1;
      else if (out_ready_i) valid_q <= 1'b0;
      // Payload only moves on a load, so it stays put while stalled.
      if (load_o) data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/fpnew_divsqrt_multi_ctrl.sv
// Purpose: sequences lane handshakes into the iterative divsqrt start/done protocol, carrying tag/aux.
// Latency: NUM_INP_REGS cycles accept->start, NUM_OUT_REGS cycles done->out_valid_o.
// Backpressure: out_ready_i low stalls output stages, then HOLD, then start, then input stages.
// Ports: lane side in_valid_i/in_ready_o/in_tag_i/in_aux_i; unit side unit_ready_i/unit_done_i/
//        fsm_start_o/reg_enable_o; result side out_valid_o/out_ready_i/out_tag_o/out_aux_o;
//        flush_i kills all in-flight work; busy_o reports any held operation.
module fpnew_divsqrt_multi_ctrl
  import fpnew_pkg::*;
#(
  parameter int unsigned  NumPipeRegs = 0,
  parameter pipe_config_t PipeConfig  = AFTER,
  parameter int unsigned  TagWidth    = 1,
  parameter int unsigned  AuxWidth    = 1,
  localparam int unsigned EnWidth     = (NumPipeRegs > 0) ? NumPipeRegs : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [TagWidth-1:0] in_tag_i,
  input  logic [AuxWidth-1:0] in_aux_i,
  input  logic                flush_i,
  input  logic                unit_ready_i,
  input  logic                unit_done_i,
  output logic                fsm_start_o,
  output logic [EnWidth-1:0]  reg_enable_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [TagWidth-1:0] out_tag_o,
  output logic [AuxWidth-1:0] out_aux_o,
  output logic                busy_o
);

  localparam int NumInpRegs = num_inp_regs(PipeConfig, int'(NumPipeRegs));
  localparam int NumOutRegs = num_out_regs(PipeConfig, int'(NumPipeRegs));

  typedef struct packed {
    logic [TagWidth-1:0] tag;
    logic [AuxWidth-1:0] aux;
  } side_t;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} fsm_state_e;

  fsm_state_e state_q;
  side_t      core_q;

  // Element 0 is the pipe entry, element N the pipe exit; with no stages they coincide.
  logic  inp_valid [0:NumInpRegs];
  logic  inp_ready [0:NumInpRegs];
  side_t inp_data  [0:NumInpRegs];
  logic  out_valid [0:NumOutRegs];
  logic  out_ready [0:NumOutRegs];
  side_t out_data  [0:NumOutRegs];

  logic core_ready;
  logic comp_valid;
  logic comp_accept;

  // ---------------- input pipe ----------------
  assign inp_valid[0] = in_valid_i;
  assign inp_data[0]  = {in_tag_i, in_aux_i};
  assign in_ready_o   = inp_ready[0];

  for (genvar i = 0; i < NumInpRegs; i++) begin : gen_inp
    fpnew_hs_stage #(.Width($bits(side_t))) u_stage (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (inp_valid[i]),
      .in_ready_o  (inp_ready[i]),
      .in_data_i   (inp_data[i]),
      .out_valid_o (inp_valid[i+1]),
      .out_ready_i (inp_ready[i+1]),
      .out_data_o  (inp_data[i+1]),
      .load_o      (reg_enable_o[i])
    );
  end

  // ---------------- core handoff ----------------
  assign core_ready               = (state_q == IDLE) & unit_ready_i & ~flush_i;
  assign inp_ready[NumInpRegs]    = core_ready;
  assign fsm_start_o              = inp_valid[NumInpRegs] & core_ready;

  // A completion is offered in the done cycle itself and for as long as it is held.
  assign comp_valid  = (((state_q == BUSY) & unit_done_i) | (state_q == HOLD)) & ~flush_i;
  assign comp_accept = comp_valid & out_ready[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      core_q  <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (fsm_start_o) begin
          state_q <= BUSY;
          core_q  <= inp_data[NumInpRegs];
        end
        BUSY: if (unit_done_i) state_q <= comp_accept ? IDLE : HOLD;
        HOLD: if (comp_accept) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------- output pipe ----------------
  assign out_valid[0]          = comp_valid;
  assign out_data[0]           = core_q;
  assign out_ready[NumOutRegs] = out_ready_i;
  assign out_valid_o           = out_valid[NumOutRegs];
  assign out_tag_o             = out_data[NumOutRegs].tag;
  assign out_aux_o             = out_data[NumOutRegs].aux;

  for (genvar i = 0; i < NumOutRegs; i++) begin : gen_out
    fpnew_hs_stage #(.Width($bits(side_t))) u_stage (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (out_valid[i]),
      .in_ready_o  (out_ready[i]),
      .in_data_i   (out_data[i]),
      .out_valid_o (out_valid[i+1]),
      .out_ready_i (out_ready[i+1]),
      .out_data_o  (out_data[i+1]),
      .load_o      (reg_enable_o[NumInpRegs+i])
    );
  end

  if (NumPipeRegs == 0) begin : gen_no_regs
    assign reg_enable_o = '0;
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    for (int i = 1; i <= NumInpRegs; i++) busy_o = busy_o | inp_valid[i];
    for (int i = 1; i <= NumOutRegs; i++) busy_o = busy_o | out_valid[i];
  end

`ifndef SYNTHESIS
  // The unit must only report completion for the operation it was started on.
  done_only_when_busy: assert property (
    @(posedge clk_i) disable iff (rst_i) unit_done_i |-> (state_q == BUSY)
  );
`endif

endmodule

// File: tb/tb_fpnew_divsqrt_multi_ctrl.sv
module tb_fpnew_divsqrt_multi_ctrl;
  import fpnew_pkg::*;

  localparam int TW = 4;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance 0: no pipeline registers.
  logic in_valid0, in_ready0, flush0, unit_ready0, unit_done0, fsm_start0;
  logic out_valid0, out_ready0, busy0;
  logic [TW-1:0] in_tag0, out_tag0;
  logic [AW-1:0] in_aux0, out_aux0;
  logic [0:0]    reg_en0;

  // Instance 2: two registers, DISTRIBUTED (one before, one after).
  logic in_valid2, in_ready2, flush2, unit_ready2, unit_done2, fsm_start2;
  logic out_valid2, out_ready2, busy2;
  logic [TW-1:0] in_tag2, out_tag2;
  logic [AW-1:0] in_aux2, out_aux2;
  logic [1:0]    reg_en2;

  fpnew_divsqrt_multi_ctrl #(.NumPipeRegs(0), .PipeConfig(AFTER), .TagWidth(TW), .AuxWidth(AW)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
    .in_tag_i(in_tag0), .in_aux_i(in_aux0), .flush_i(flush0), .unit_ready_i(unit_ready0),
    .unit_done_i(unit_done0), .fsm_start_o(fsm_start0), .reg_enable_o(reg_en0),
    .out_valid_o(out_valid0), .out_ready_i(out_ready0), .out_tag_o(out_tag0),
    .out_aux_o(out_aux0), .busy_o(busy0));

  fpnew_divsqrt_multi_ctrl #(.NumPipeRegs(2), .PipeConfig(DISTRIBUTED), .TagWidth(TW), .AuxWidth(AW)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .in_tag_i(in_tag2), .in_aux_i(in_aux2), .flush_i(flush2), .unit_ready_i(unit_ready2),
    .unit_done_i(unit_done2), .fsm_start_o(fsm_start2), .reg_enable_o(reg_en2),
    .out_valid_o(out_valid2), .out_ready_i(out_ready2), .out_tag_o(out_tag2),
    .out_aux_o(out_aux2), .busy_o(busy2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle0;
    in_valid0 = 0; in_tag0 = '0; in_aux0 = '0; flush0 = 0;
    unit_ready0 = 1; unit_done0 = 0; out_ready0 = 1;
  endtask

  task automatic idle2;
    in_valid2 = 0; in_tag2 = '0; in_aux2 = '0; flush2 = 0;
    unit_ready2 = 1; unit_done2 = 0; out_ready2 = 1;
  endtask

  // Single-op scenario records for the unbuffered instance.
  typedef struct {
    logic [TW-1:0] tag;
    logic [AW-1:0] aux;
    int            lat;      // cycles from start to unit_done
    int            hold;     // cycles after done with out_ready low (last one releases)
    logic [TW-1:0] exp_tag;
    logic [AW-1:0] exp_aux;
  } vec_t;

  task automatic run_op0(input vec_t v);
    int bad;
    bad = 0;
    in_valid0 = 1; in_tag0 = v.tag; in_aux0 = v.aux;
    unit_ready0 = 1; unit_done0 = 0; out_ready0 = 1; flush0 = 0;
    #1;
    chk("op0_in_ready", in_ready0, 1);
    chk("op0_start", fsm_start0, 1);
    chk("op0_busy_before", busy0, 0);
    tick;
    // A competing offer with the unit nominally ready must not start while busy.
    in_tag0 = ~v.tag;
    for (int c = 1; c < v.lat; c++) begin
      #1;
      bad += int'(fsm_start0) + int'(out_valid0) + int'(in_ready0);
      tick;
    end
    chk("op0_quiet_while_busy", bad, 0);
    unit_done0 = 1; out_ready0 = (v.hold == 0);
    #1;
    chk("op0_done_valid", out_valid0, 1);
    chk("op0_done_tag", out_tag0, v.exp_tag);
    chk("op0_done_aux", out_aux0, v.exp_aux);
    chk("op0_done_start", fsm_start0, 0);
    tick;
    unit_done0 = 0;
    for (int h = 1; h <= v.hold; h++) begin
      out_ready0 = (h == v.hold);
      #1;
      chk("op0_hold_valid", out_valid0, 1);
      chk("op0_hold_tag", out_tag0, v.exp_tag);
      chk("op0_hold_in_ready", in_ready0, 0);
      tick;
    end
    in_valid0 = 0; out_ready0 = 1;
    #1;
    chk("op0_drained", out_valid0, 0);
  endtask

  // Streams ops through instance 2 against a FIFO reference and a simple unit model.
  task automatic stream(input int n_ops, input int fixed_lat, input bit seq_tags,
                        input int p_in, input int p_out, input int max_cycles);
    logic [TW+AW-1:0] exp_q[$];
    logic [TW+AW-1:0] exp_v, prev_pay;
    bit  prev_stall, unit_busy;
    int  unit_cnt, sent, got, cyc, n_start;
    sent = 0; got = 0; cyc = 0; n_start = 0;
    prev_stall = 0; prev_pay = '0; unit_busy = 0; unit_cnt = 0;
    while (got < n_ops && cyc < max_cycles) begin
      in_valid2 = (sent < n_ops) && ($urandom_range(99) < p_in);
      in_tag2   = seq_tags ? TW'(sent + 1) : TW'($urandom);
      in_aux2   = seq_tags ? '0 : AW'($urandom);
      out_ready2  = ($urandom_range(99) < p_out);
      unit_done2  = unit_busy && (unit_cnt == 0);
      unit_ready2 = !unit_busy;
      #1;
      if (prev_stall) chk("stream_stall_stable", {out_valid2, out_tag2, out_aux2}, {1'b1, prev_pay});
      if (in_valid2 && in_ready2) begin
        exp_q.push_back({in_tag2, in_aux2});
        sent++;
      end
      if (out_valid2 && out_ready2) begin
        if (exp_q.size() == 0) chk("stream_spurious_out", out_valid2, 0);
        else begin
          exp_v = exp_q.pop_front();
          chk("stream_out_order", {out_tag2, out_aux2}, exp_v);
        end
        got++;
      end
      prev_stall = out_valid2 && !out_ready2;
      prev_pay   = {out_tag2, out_aux2};
      if (fsm_start2) begin
        n_start++;
        unit_busy = 1;
        unit_cnt  = (fixed_lat > 0) ? fixed_lat - 1 : int'($urandom_range(4));
      end else if (unit_done2) unit_busy = 0;
      else if (unit_busy) unit_cnt--;
      tick;
      cyc++;
    end
    chk("stream_completed", got, n_ops);
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_starts", n_start, n_ops);
    idle2;
    tick;
    #1;
    chk("stream_busy_end", busy2, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt [0:6];
    vt[0] = '{4'd5,  3'd1, 12, 0,  4'd5,  3'd1};
    vt[1] = '{4'd1,  3'd2, 8,  0,  4'd1,  3'd2};
    vt[2] = '{4'd2,  3'd3, 8,  0,  4'd2,  3'd3};
    vt[3] = '{4'd3,  3'd4, 8,  0,  4'd3,  3'd4};
    vt[4] = '{4'd10, 3'd5, 3,  11, 4'd10, 3'd5};
    vt[5] = '{4'd15, 3'd7, 1,  2,  4'd15, 3'd7};
    vt[6] = '{4'd0,  3'd6, 2,  1,  4'd0,  3'd6};

    rst = 1; idle0; idle2;
    repeat (2) tick;
    rst = 0;
    #1;
    chk("rst_start0", fsm_start0, 0);
    chk("rst_ov0", out_valid0, 0);
    chk("rst_re0", reg_en0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_tag0", out_tag0, 0);
    chk("rst_in_ready0", in_ready0, 1);
    chk("rst_start2", fsm_start2, 0);
    chk("rst_ov2", out_valid2, 0);
    chk("rst_re2", reg_en2, 0);
    chk("rst_busy2", busy2, 0);
    tick;

    // Table of single operations, run back to back.
    for (int r = 0; r < 7; r++) run_op0(vt[r]);
    idle0;
    tick;

    // DISTRIBUTED: accept at 0, start at 1, done at 20, result at 21.
    for (int c = 0; c <= 22; c++) begin
      in_valid2 = (c == 0); in_tag2 = 4'h3; in_aux2 = 3'h2;
      unit_ready2 = (c <= 1); unit_done2 = (c == 20); out_ready2 = 1; flush2 = 0;
      #1;
      chk("dist_reg_enable", reg_en2, (c == 0) ? 32'd1 : (c == 20) ? 32'd2 : 32'd0);
      chk("dist_start", fsm_start2, (c == 1));
      chk("dist_out_valid", out_valid2, (c == 21));
      if (c == 21) chk("dist_out_tag", out_tag2, 3);
      tick;
    end
    idle2;

    // Flush in the done cycle on instance 0: no result, idle next cycle.
    in_valid0 = 1; in_tag0 = 4'd7; in_aux0 = 3'd1;
    #1;
    chk("flush_start", fsm_start0, 1);
    tick;
    in_valid0 = 0; unit_ready0 = 0;
    repeat (3) tick;
    unit_done0 = 1; flush0 = 1; in_valid0 = 1; in_tag0 = 4'd8; unit_ready0 = 1;
    #1;
    chk("flush_no_out", out_valid0, 0);
    chk("flush_in_ready", in_ready0, 0);
    chk("flush_no_start", fsm_start0, 0);
    tick;
    unit_done0 = 0; flush0 = 0; in_valid0 = 0;
    #1;
    chk("flush_busy_after", busy0, 0);
    chk("flush_ov_after", out_valid0, 0);
    chk("flush_in_ready_after", in_ready0, 1);
    run_op0('{4'd9, 3'd3, 2, 0, 4'd9, 3'd3});
    idle0;
    tick;

    // Flush with a loaded input stage on instance 2: offer in the flush cycle is dropped.
    in_valid2 = 1; in_tag2 = 4'd4; unit_ready2 = 0;
    #1;
    chk("flush2_load", reg_en2, 1);
    tick;
    in_tag2 = 4'd6; flush2 = 1;
    #1;
    chk("flush2_in_ready", in_ready2, 0);
    chk("flush2_reg_enable", reg_en2, 0);
    chk("flush2_start", fsm_start2, 0);
    tick;
    idle2;
    #1;
    chk("flush2_busy_after", busy2, 0);
    tick;

    // Reset while holding a completed result.
    in_valid0 = 1; in_tag0 = 4'hA; in_aux0 = 3'd5;
    tick;
    in_valid0 = 0; unit_ready0 = 0; unit_done0 = 1; out_ready0 = 0;
    tick;
    unit_done0 = 0;
    #1;
    chk("rsthold_valid", out_valid0, 1);
    chk("rsthold_tag", out_tag0, 4'hA);
    rst = 1;
    tick;
    rst = 0;
    #1;
    chk("rsthold_ov", out_valid0, 0);
    chk("rsthold_start", fsm_start0, 0);
    chk("rsthold_re", reg_en0, 0);
    chk("rsthold_tag_clr", out_tag0, 0);
    chk("rsthold_aux_clr", out_aux0, 0);
    chk("rsthold_busy", busy0, 0);
    idle0;
    tick;

    // Back-to-back tags 1,2,3 with unit busy 8 cycles per op, then randomized traffic.
    stream(3, 8, 1'b1, 100, 100, 300);
    stream(150, 0, 1'b0, 60, 60, 6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
